// File: rtl/glitch_sequencer.sv
// Triggered glitch pulse generator: on an accepted trigger edge it waits a delay,
// then emits a train of pulses with programmable width, gap and count.
module glitch_sequencer #(
    parameter int CNT_W  = 16,
    parameter int REP_W  = 8,
    parameter int TCNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trigger,
    input  logic              abort,
    input  logic [CNT_W-1:0]  delay,
    input  logic [CNT_W-1:0]  width,
    input  logic [CNT_W-1:0]  gap,
    input  logic [REP_W-1:0]  repeat_n,
    output logic              out,
    output logic              busy,
    output logic              done,
    output logic [TCNT_W-1:0] trig_count
);

    typedef enum logic [1:0] {IDLE, DELAY, PULSE, GAP} state_t;

    state_t             r_state;
    logic               r_trig_d;
    logic               r_armed;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   r_width;
    logic [CNT_W-1:0]   r_gap;
    logic [REP_W-1:0]   r_rep;

    logic               w_rise;
    logic [CNT_W-1:0]   w_width_m1;
    logic [CNT_W-1:0]   w_gap_m1;
    logic [REP_W-1:0]   w_rep_m1;

    // r_armed blocks a trigger that is already high on the first edge out of reset
    assign w_rise     = trigger & ~r_trig_d & r_armed;
    // Zero-valued fields behave as 1; store terminal counts (value-1) so all-ones never overflows
    assign w_width_m1 = (width == '0)    ? '0 : width - CNT_W'(1);
    assign w_gap_m1   = (gap == '0)      ? '0 : gap - CNT_W'(1);
    assign w_rep_m1   = (repeat_n == '0) ? '0 : repeat_n - REP_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_trig_d   <= 1'b0;
            r_armed    <= 1'b0;
            r_cnt      <= '0;
            r_width    <= '0;
            r_gap      <= '0;
            r_rep      <= '0;
            out        <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            trig_count <= '0;
        end else begin
            r_trig_d <= trigger;
            r_armed  <= 1'b1;
            done     <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_rise && !abort) begin
                        r_cnt      <= delay;
                        r_width    <= w_width_m1;
                        r_gap      <= w_gap_m1;
                        r_rep      <= w_rep_m1;
                        busy       <= 1'b1;
                        trig_count <= trig_count + TCNT_W'(1);
                        r_state    <= DELAY;
                    end
                end
                DELAY: begin
                    if (r_cnt == '0) begin
                        out     <= 1'b1;
                        r_cnt   <= r_width;
                        r_state <= PULSE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                PULSE: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else if (r_rep == '0) begin
                        out     <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        out     <= 1'b0;
                        r_cnt   <= r_gap;
                        r_rep   <= r_rep - REP_W'(1);
                        r_state <= GAP;
                    end
                end
                GAP: begin
                    if (r_cnt == '0) begin
                        out     <= 1'b1;
                        r_cnt   <= r_width;
                        r_state <= PULSE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
            // Abort overrides whatever the state logic chose, including a completion strobe
            if (abort && r_state != IDLE) begin
                out     <= 1'b0;
                busy    <= 1'b0;
                done    <= 1'b0;
                r_state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_glitch_sequencer.sv
// Scoreboard bench for glitch_sequencer: expected out/busy/done per cycle are
// queued from the timing rules when a trigger is launched and popped each cycle.
module tb_glitch_sequencer;

    typedef struct packed {
        logic o;
        logic b;
        logic d;
    } exp_t;

    logic        clk, rst, trigger, abort;
    logic [15:0] delay, width, gap;
    logic [7:0]  rep;
    logic        out, busy, done;
    logic [7:0]  trig_count;

    logic [7:0]  d8, w8, g8;
    logic [1:0]  r8;
    logic        out8, busy8, done8;
    logic [7:0]  cnt8;

    exp_t        sb[$];
    exp_t        e;
    logic [7:0]  exp_cnt;
    int          n_cmp, n_bad;

    glitch_sequencer dut (
        .clk(clk), .rst(rst), .trigger(trigger), .abort(abort),
        .delay(delay), .width(width), .gap(gap), .repeat_n(rep),
        .out(out), .busy(busy), .done(done), .trig_count(trig_count)
    );

    glitch_sequencer #(.CNT_W(8), .REP_W(2), .TCNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .trigger(trigger), .abort(abort),
        .delay(d8), .width(w8), .gap(g8), .repeat_n(r8),
        .out(out8), .busy(busy8), .done(done8), .trig_count(cnt8)
    );

    always #5 clk = ~clk;

    // Expected per-edge outputs starting at the edge that accepts the trigger
    task automatic build(input int d, input int w, input int g, input int r);
        int wq, gq, rq;
        wq = (w == 0) ? 1 : w;
        gq = (g == 0) ? 1 : g;
        rq = (r == 0) ? 1 : r;
        for (int i = 0; i <= d; i++) sb.push_back('{1'b0, 1'b1, 1'b0});
        for (int p = 0; p < rq; p++) begin
            for (int i = 0; i < wq; i++) sb.push_back('{1'b1, 1'b1, 1'b0});
            if (p < rq - 1)
                for (int i = 0; i < gq; i++) sb.push_back('{1'b0, 1'b1, 1'b0});
        end
        sb.push_back('{1'b0, 1'b0, 1'b1});
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++;
        if ({out, busy, done, trig_count, cnt8} !== 19'd0) begin
            n_bad++;
            $display("FAIL reset: got out/busy/done=%b%b%b cnt=%0d cnt8=%0d, want all 0",
                     out, busy, done, trig_count, cnt8);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        sb.delete();
        build(3, 2, 4, 1);
        delay = 16'd3; width = 16'd2; gap = 16'd4; rep = 8'd1;
        trigger = 1'b1;
        for (int i = 0; sb.size() > 0; i++) begin
            @(negedge clk);
            e = sb.pop_front();
            n_cmp++;
            if ({out, busy, done} !== e) begin
                n_bad++;
                $display("FAIL basic[%0d]: got %b%b%b want %b", i, out, busy, done, e);
            end
            if (i == 0) begin
                trigger = 1'b0;
                delay = 16'($urandom); width = 16'($urandom);
                gap = 16'($urandom);   rep = 8'($urandom);
            end
        end
        exp_cnt++;
        n_cmp++;
        if (trig_count !== exp_cnt) begin
            n_bad++;
            $display("FAIL basic_count: got %0d want %0d", trig_count, exp_cnt);
        end
    endtask

    task automatic test_repeat();
        sb.delete();
        build(0, 1, 2, 3);
        delay = 16'd0; width = 16'd1; gap = 16'd2; rep = 8'd3;
        trigger = 1'b1;
        for (int i = 0; sb.size() > 0; i++) begin
            @(negedge clk);
            e = sb.pop_front();
            n_cmp++;
            if ({out, busy, done} !== e) begin
                n_bad++;
                $display("FAIL repeat[%0d]: got %b%b%b want %b", i, out, busy, done, e);
            end
            if (i == 0) trigger = 1'b0;
        end
        exp_cnt++;
        @(negedge clk);
        n_cmp++;
        if ({done, trig_count} !== {1'b0, exp_cnt}) begin
            n_bad++;
            $display("FAIL repeat_tail: got done=%b cnt=%0d want done=0 cnt=%0d", done, trig_count, exp_cnt);
        end
    endtask

    task automatic test_zero_fields();
        sb.delete();
        build(4, 0, 0, 0);
        delay = 16'd4; width = 16'd0; gap = 16'd0; rep = 8'd0;
        trigger = 1'b1;
        for (int i = 0; sb.size() > 0; i++) begin
            @(negedge clk);
            e = sb.pop_front();
            n_cmp++;
            if ({out, busy, done} !== e) begin
                n_bad++;
                $display("FAIL zero[%0d]: got %b%b%b want %b", i, out, busy, done, e);
            end
            if (i == 0) trigger = 1'b0;
            if (i == 1) trigger = 1'b1;   // new edge during DELAY, must be ignored
            if (i == 3) trigger = 1'b0;
        end
        exp_cnt++;
        n_cmp++;
        if (trig_count !== exp_cnt) begin
            n_bad++;
            $display("FAIL zero_count: got %0d want %0d", trig_count, exp_cnt);
        end
    endtask

    task automatic test_back_to_back();
        bit rearmed;
        // held trigger across completion: not a new edge
        sb.delete();
        build(0, 1, 1, 1);
        delay = 16'd0; width = 16'd1; gap = 16'd1; rep = 8'd1;
        trigger = 1'b1;
        while (sb.size() > 0) begin
            @(negedge clk);
            e = sb.pop_front();
            n_cmp++;
            if ({out, busy, done} !== e) begin
                n_bad++;
                $display("FAIL held: got %b%b%b want %b", out, busy, done, e);
            end
        end
        exp_cnt++;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy, trig_count} !== {1'b0, exp_cnt}) begin
            n_bad++;
            $display("FAIL held_idle: got busy=%b cnt=%0d want busy=0 cnt=%0d", busy, trig_count, exp_cnt);
        end
        trigger = 1'b0;
        @(negedge clk);
        // new edge launched during the done cycle
        sb.delete();
        build(1, 2, 1, 2);
        build(2, 1, 0, 1);
        delay = 16'd1; width = 16'd2; gap = 16'd1; rep = 8'd2;
        trigger = 1'b1;
        rearmed = 1'b0;
        for (int i = 0; sb.size() > 0; i++) begin
            @(negedge clk);
            e = sb.pop_front();
            n_cmp++;
            if ({out, busy, done} !== e) begin
                n_bad++;
                $display("FAIL b2b[%0d]: got %b%b%b want %b", i, out, busy, done, e);
            end
            if (i == 0) begin
                trigger = 1'b0;
                delay = 16'd2; width = 16'd1; gap = 16'd0; rep = 8'd1;
            end else if (e.d && !rearmed) begin
                trigger = 1'b1;
                rearmed = 1'b1;
            end else if (rearmed) begin
                trigger = 1'b0;
            end
        end
        exp_cnt = exp_cnt + 8'd2;
        n_cmp++;
        if (trig_count !== exp_cnt) begin
            n_bad++;
            $display("FAIL b2b_count: got %0d want %0d", trig_count, exp_cnt);
        end
    endtask

    task automatic test_abort();
        sb.delete();
        build(1, 3, 2, 4);
        delay = 16'd1; width = 16'd3; gap = 16'd2; rep = 8'd4;
        trigger = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            e = sb.pop_front();
            n_cmp++;
            if ({out, busy, done} !== e) begin
                n_bad++;
                $display("FAIL abort_pre[%0d]: got %b%b%b want %b", i, out, busy, done, e);
            end
            if (i == 0) trigger = 1'b0;
        end
        abort = 1'b1;   // inside the second pulse
        sb.delete();
        exp_cnt++;
        @(negedge clk);
        abort = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if ({out, busy, done} !== 3'b000) begin
                n_bad++;
                $display("FAIL abort_post[%0d]: got %b%b%b want 000", i, out, busy, done);
            end
            @(negedge clk);
        end
        // abort with a same-cycle edge in IDLE: edge dropped
        abort = 1'b1; trigger = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({busy, trig_count} !== {1'b0, exp_cnt}) begin
            n_bad++;
            $display("FAIL abort_prio: got busy=%b cnt=%0d want busy=0 cnt=%0d", busy, trig_count, exp_cnt);
        end
        trigger = 1'b0;
        @(negedge clk);
        sb.delete();
        build(0, 2, 1, 1);
        delay = 16'd0; width = 16'd2; gap = 16'd1; rep = 8'd1;
        trigger = 1'b1;
        for (int i = 0; sb.size() > 0; i++) begin
            @(negedge clk);
            e = sb.pop_front();
            n_cmp++;
            if ({out, busy, done} !== e) begin
                n_bad++;
                $display("FAIL abort_next[%0d]: got %b%b%b want %b", i, out, busy, done, e);
            end
            if (i == 0) trigger = 1'b0;
        end
        exp_cnt++;
        n_cmp++;
        if (trig_count !== exp_cnt) begin
            n_bad++;
            $display("FAIL abort_count: got %0d want %0d", trig_count, exp_cnt);
        end
    endtask

    task automatic test_reset_mid();
        delay = 16'd2; width = 16'd5; gap = 16'd1; rep = 8'd1;
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (out !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_mid_pre: got out=%b want 1", out);
        end
        trigger = 1'b1;
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({out, busy, done, trig_count} !== 11'd0) begin
            n_bad++;
            $display("FAIL rst_mid: got %b%b%b cnt=%0d want 000 cnt=0", out, busy, done, trig_count);
        end
        exp_cnt = 8'd0;
        @(negedge clk);
        rst = 1'b0;   // trigger already high: first edge must not accept
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy, done, trig_count} !== 10'd0) begin
            n_bad++;
            $display("FAIL rst_held_trig: got busy=%b done=%b cnt=%0d want 0/0/0", busy, done, trig_count);
        end
        trigger = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_wrap();
        delay = 16'd0; width = 16'd1; gap = 16'd1; rep = 8'd1;
        for (int k = 0; k < 256; k++) begin
            trigger = 1'b1;
            @(negedge clk);
            trigger = 1'b0;
            repeat (4) @(negedge clk);
            exp_cnt++;
            if (k == 254) begin
                n_cmp++;
                if (trig_count !== 8'd255) begin
                    n_bad++;
                    $display("FAIL wrap_255: got %0d want 255", trig_count);
                end
            end
        end
        n_cmp++;
        if (trig_count !== exp_cnt || exp_cnt !== 8'd0) begin
            n_bad++;
            $display("FAIL wrap_0: got %0d want %0d", trig_count, exp_cnt);
        end
    endtask

    task automatic test_all_ones();
        sb.delete();
        build(255, 255, 255, 3);
        d8 = 8'hFF; w8 = 8'hFF; g8 = 8'hFF; r8 = 2'b11;
        trigger = 1'b1;
        for (int i = 0; sb.size() > 0; i++) begin
            @(negedge clk);
            e = sb.pop_front();
            n_cmp++;
            if ({out8, busy8, done8} !== e) begin
                n_bad++;
                $display("FAIL all_ones[%0d]: got %b%b%b want %b", i, out8, busy8, done8, e);
            end
            if (i == 0) trigger = 1'b0;
        end
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1; trigger = 1'b0; abort = 1'b0;
        delay = '0; width = '0; gap = '0; rep = '0;
        d8 = '0; w8 = '0; g8 = '0; r8 = '0;
        exp_cnt = 8'd0; n_cmp = 0; n_bad = 0;
        test_reset();
        test_basic();
        test_repeat();
        test_zero_fields();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_wrap();
        test_all_ones();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/glitch_sequencer.md
GLITCH_SEQUENCER -- requirements
Module: glitch_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of delay/width/gap timing fields.
REQ-002 SHALL have parameter REP_W, default 8, width of pulse repeat-count field.
REQ-003 SHALL have parameter TCNT_W, default 8, width of accepted-trigger counter.
REQ-004 SHALL have ports, one per line:
- clk  in  1  single system clock, all state on rising edge
- rst  in  1  asynchronous reset, active-high
- trigger  in  1  debounced trigger level, synchronous to clk
- abort  in  1  synchronous abort request, active-high
- delay  in  CNT_W  cycles from trigger to first pulse
- width  in  CNT_W  pulse high time, cycles
- gap  in  CNT_W  low time between pulses, cycles
- repeat  in  REP_W  number of pulses per trigger
- out  out  1  registered glitch output
- busy  out  1  high while a sequence is running
- done  out  1  one-cycle strobe at normal sequence completion
- trig_count  out  TCNT_W  number of accepted triggers

Function
REQ-005 SHALL register trigger each cycle; a rising edge is trigger=1 with the previous sample 0.
REQ-006 SHALL implement states IDLE, DELAY, PULSE, GAP; all outputs registered.
REQ-007 SHALL accept a rising edge only in IDLE; it latches delay/width/gap/repeat, increments trig_count, and sets busy on the next edge.
REQ-008 SHALL ignore rising edges outside IDLE: no latch, no count change.
REQ-009 SHALL hold latched values for the whole sequence; input changes mid-sequence have no effect.
REQ-010 SHALL raise out exactly delay+1 clock edges after the edge sampling the accepted trigger edge; delay=0 gives 1 cycle.
REQ-011 SHALL hold out high for max(width,1) cycles per pulse.
REQ-012 SHALL hold out low for max(gap,1) cycles between consecutive pulses.
REQ-013 SHALL emit max(repeat,1) pulses per accepted trigger.
REQ-014 SHALL, on the cycle after the last pulse's final high cycle, drive out=0, busy=0, done=1 for one cycle, and re-enter IDLE.
REQ-015 SHALL accept a new rising edge on the same cycle done=1 (IDLE reached); a trigger held high across completion is not a new edge.
REQ-016 SHALL, on abort=1 in any non-IDLE state, drive out=0 and busy=0 on the next edge, return to IDLE, and not assert done.
REQ-017 SHALL give abort priority over a same-cycle trigger edge; that edge is not accepted or counted.
REQ-018 SHALL wrap trig_count modulo 2^TCNT_W.
REQ-019 SHALL use counters of CNT_W/REP_W bits without overflow; all-ones inputs are legal.

Reset
REQ-020 SHALL asynchronously force, on rst=1: state IDLE, out=0, busy=0, done=0, trig_count=0, edge register=0, latched fields=0.
REQ-021 SHALL abandon any sequence in progress on reset, with no done strobe.
REQ-022 SHALL not accept a trigger edge on the first edge after rst deasserts if trigger was already high.

Verification
REQ-023 delay=3, width=2, gap=4, repeat=1, trigger 0->1 sampled at edge T -> out high at edges T+4..T+5, done=1 at T+6, trig_count=1.
REQ-024 delay=0, width=1, gap=2, repeat=3 -> out pattern 1,0,0,1,0,0,1 from T+1; done=1 once after the third pulse.
REQ-025 width=0, gap=0, repeat=0 -> treated as 1: single 1-cycle pulse; second trigger edge during DELAY -> ignored, trig_count unchanged.
REQ-026 abort asserted during second pulse of repeat=4 -> out=0 and busy=0 next edge, no done, next trigger edge accepted normally.
REQ-027 rst pulsed mid-PULSE -> out, busy, trig_count zero immediately; 256 accepted triggers with TCNT_W=8 -> trig_count wraps to 0.
REQ-028 delay=65535, width=65535 at CNT_W=16 -> out rises after 65536 cycles, stays high 65535 cycles, no early termination.
